// File: rtl/core_ctrl_fsm.sv
// Multicycle RV32I control FSM: fetch, decode, execute, memory, writeback.
// Drives datapath strobes, one-hot immediate selects, bus request handshakes
// and the retired-instruction counter.
// Optional feature macro: CORE_CTRL_ILLEGAL_TRAP_EN (illegal opcode halts the
// core and raises a sticky illegal_inst_o; otherwise it retires as a NOP).
module core_ctrl_fsm #(
  parameter int unsigned RETIRE_CNT_W = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [31:0]             inst_i,
  input  logic                    branch_taken_i,
  output logic                    instr_req_o,
  input  logic                    instr_gnt_i,
  input  logic                    instr_rvalid_i,
  output logic                    data_req_o,
  output logic                    data_we_o,
  input  logic                    data_gnt_i,
  input  logic                    data_rvalid_i,
  output logic                    ir_we_o,
  output logic                    pc_we_o,
  output logic                    pc_sel_alu_o,
  output logic                    rf_we_o,
  output logic                    ctrl_sel_imm_i_o,
  output logic                    ctrl_sel_imm_s_o,
  output logic                    ctrl_sel_imm_b_o,
  output logic                    ctrl_sel_imm_u_o,
  output logic                    ctrl_sel_imm_j_o,
  output logic                    retire_o,
  output logic [RETIRE_CNT_W-1:0] instret_o,
  output logic                    halted_o,
  output logic                    illegal_inst_o
);

  typedef enum logic [2:0] {
    S_FETCH_REQ, S_FETCH_WAIT, S_DECODE, S_EXEC,
    S_MEM_REQ, S_MEM_WAIT, S_WB, S_HALT
  } state_e;

  typedef enum logic [6:0] {
    OPC_LOAD     = 7'b0000011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_OP_IMM   = 7'b0010011,
    OPC_AUIPC    = 7'b0010111,
    OPC_STORE    = 7'b0100011,
    OPC_OP       = 7'b0110011,
    OPC_LUI      = 7'b0110111,
    OPC_BRANCH   = 7'b1100011,
    OPC_JALR     = 7'b1100111,
    OPC_JAL      = 7'b1101111,
    OPC_SYSTEM   = 7'b1110011
  } opcode_e;

  state_e                  state_q, state_d;
  logic [RETIRE_CNT_W-1:0] instret_q;
  logic [6:0]              opc;
  logic                    legal, is_mem, is_store, is_branch, is_jump, is_sys, no_rd;
  logic                    sel_i, sel_s, sel_b, sel_u, sel_j, imm_active;
  logic                    instr_req_c, ir_we_c;
  logic                    unused_inst;

  assign opc         = inst_i[6:0];
  assign unused_inst = ^inst_i[31:7];

  // Opcode classification and immediate-type decode
  always_comb begin
    legal     = 1'b0;
    is_mem    = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    is_sys    = 1'b0;
    no_rd     = 1'b0;
    sel_i     = 1'b0;
    sel_s     = 1'b0;
    sel_b     = 1'b0;
    sel_u     = 1'b0;
    sel_j     = 1'b0;
    case (opc)
      OPC_LOAD:     begin legal = 1'b1; is_mem = 1'b1; sel_i = 1'b1; end
      OPC_STORE:    begin legal = 1'b1; is_mem = 1'b1; is_store = 1'b1; no_rd = 1'b1; sel_s = 1'b1; end
      OPC_OP_IMM:   begin legal = 1'b1; sel_i = 1'b1; end
      OPC_OP:       legal = 1'b1;
      OPC_LUI,
      OPC_AUIPC:    begin legal = 1'b1; sel_u = 1'b1; end
      OPC_BRANCH:   begin legal = 1'b1; is_branch = 1'b1; no_rd = 1'b1; sel_b = 1'b1; end
      OPC_JALR:     begin legal = 1'b1; is_jump = 1'b1; sel_i = 1'b1; end
      OPC_JAL:      begin legal = 1'b1; is_jump = 1'b1; sel_j = 1'b1; end
      OPC_MISC_MEM: begin legal = 1'b1; no_rd = 1'b1; end
      OPC_SYSTEM:   begin legal = 1'b1; is_sys = 1'b1; end
      default:      legal = 1'b0;
    endcase
  end

  assign imm_active = (state_q == S_DECODE) || (state_q == S_EXEC) ||
                      (state_q == S_MEM_REQ) || (state_q == S_MEM_WAIT) ||
                      (state_q == S_WB);
  assign ctrl_sel_imm_i_o = sel_i & imm_active;
  assign ctrl_sel_imm_s_o = sel_s & imm_active;
  assign ctrl_sel_imm_b_o = sel_b & imm_active;
  assign ctrl_sel_imm_u_o = sel_u & imm_active;
  assign ctrl_sel_imm_j_o = sel_j & imm_active;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_FETCH_REQ;
    else         state_q <= state_d;
  end

  // Next-state and strobe generation
  always_comb begin
    state_d      = state_q;
    instr_req_c  = 1'b0;
    ir_we_c      = 1'b0;
    data_req_o   = 1'b0;
    data_we_o    = 1'b0;
    pc_we_o      = 1'b0;
    pc_sel_alu_o = 1'b0;
    rf_we_o      = 1'b0;
    retire_o     = 1'b0;
    halted_o     = 1'b0;
    case (state_q)
      S_FETCH_REQ: begin
        instr_req_c = 1'b1;
        if (instr_gnt_i) begin
          ir_we_c = instr_rvalid_i;
          state_d = instr_rvalid_i ? S_DECODE : S_FETCH_WAIT;
        end
      end
      S_FETCH_WAIT: begin
        if (instr_rvalid_i) begin
          ir_we_c = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
`ifdef CORE_CTRL_ILLEGAL_TRAP_EN
        state_d = legal ? S_EXEC : S_HALT;
`else
        state_d = S_EXEC;
`endif
      end
      S_EXEC: begin
        if (is_mem)      state_d = S_MEM_REQ;
        else if (is_sys) state_d = S_HALT;
        else             state_d = S_WB;
      end
      S_MEM_REQ: begin
        data_req_o = 1'b1;
        data_we_o  = is_store;
        if (data_gnt_i) state_d = data_rvalid_i ? S_WB : S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        if (data_rvalid_i) state_d = S_WB;
      end
      S_WB: begin
        pc_we_o      = 1'b1;
        retire_o     = 1'b1;
        rf_we_o      = legal & ~no_rd;
        pc_sel_alu_o = is_jump | (is_branch & branch_taken_i);
        state_d      = S_FETCH_REQ;
      end
      S_HALT: halted_o = 1'b1;
      default: state_d = S_FETCH_REQ;
    endcase
  end

  // The reset state is FETCH_REQ, so fetch strobes are masked while rst_ni is low
  assign instr_req_o = instr_req_c & rst_ni;
  assign ir_we_o     = ir_we_c & rst_ni;

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)               instret_q <= '0;
    else if (state_q == S_WB) instret_q <= instret_q + RETIRE_CNT_W'(1);
  end
  assign instret_o = instret_q;

`ifdef CORE_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;
  // Sticky illegal-instruction flag, set when DECODE sees an illegal opcode
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                            illegal_q <= 1'b0;
    else if (state_q == S_DECODE && !legal) illegal_q <= 1'b1;
  end
  assign illegal_inst_o = illegal_q;
`else
  assign illegal_inst_o = 1'b0;
`endif

endmodule
